// File: rtl/grng_pkg.sv
// Shared types for the Gaussian RNG back end: Q7.28 sample word and the
// buffered sample record (tail flag plus value).
package grng_pkg;

    localparam int FRAC_BITS = 28;
    localparam int SAMPLE_W  = 36;

    typedef logic signed [SAMPLE_W-1:0] q7_28_t;

    typedef struct packed {
        logic   tail;
        q7_28_t data;
    } sample_t;

endpackage

// File: rtl/grng_sample_collector_if.sv
// Bundle of the Ziggurat result inputs, the sample stream towards the consumer
// and the statistics/back-pressure signals of the sample collector.
interface grng_sample_collector_if #(
    parameter int CNT_W = 32
);
    import grng_pkg::*;

    logic             in_valid;
    logic             in_tail_case;
    logic             in_reject;
    q7_28_t           in_normal_value;
    q7_28_t           in_tail_value;
    logic             gen_enable;
    logic             out_valid;
    logic             out_ready;
    q7_28_t           out_data;
    logic             out_tail;
    logic             clear_stats;
    logic [CNT_W-1:0] accept_cnt;
    logic [CNT_W-1:0] reject_cnt;
    logic             overflow;

    modport slave (
        input  in_valid, in_tail_case, in_reject, in_normal_value, in_tail_value,
        input  out_ready, clear_stats,
        output gen_enable, out_valid, out_data, out_tail,
        output accept_cnt, reject_cnt, overflow
    );

    modport master (
        output in_valid, in_tail_case, in_reject, in_normal_value, in_tail_value,
        output out_ready, clear_stats,
        input  gen_enable, out_valid, out_data, out_tail,
        input  accept_cnt, reject_cnt, overflow
    );

endinterface

// File: rtl/grng_fwft_fifo.sv
// First-word-fall-through sync FIFO of samples with occupancy count; a push
// into a full FIFO is still accepted when a pop happens in the same cycle.
module grng_fwft_fifo
    import grng_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int LOG2D = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic           pop_i,
    input  sample_t        wdata_i,
    output sample_t        rdata_o,
    output logic           pushOk_o,
    output logic [LOG2D:0] count_o,
    output logic [LOG2D:0] countNext_o
);

    sample_t          mem [DEPTH];
    logic [LOG2D-1:0] wrPtr_q, wrPtr_d;
    logic [LOG2D-1:0] rdPtr_q, rdPtr_d;
    logic [LOG2D:0]   count_q, count_d;
    logic             empty, full, doPush, doPop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (LOG2D+1)'(DEPTH));

    // Pointers are LOG2D bits wide, so the increment wraps modulo DEPTH.
    always_comb begin
        doPop   = pop_i && !empty;
        doPush  = push_i && (!full || doPop);
        wrPtr_d = doPush ? wrPtr_q + LOG2D'(1) : wrPtr_q;
        rdPtr_d = doPop  ? rdPtr_q + LOG2D'(1) : rdPtr_q;
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + (LOG2D+1)'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - (LOG2D+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= wdata_i;
        end
    end

    assign rdata_o     = empty ? '0 : mem[rdPtr_q];
    assign pushOk_o    = doPush;
    assign count_o     = count_q;
    assign countNext_o = count_d;

endmodule

// File: rtl/grng_sample_collector.sv
// Collects surviving Ziggurat samples into a FWFT FIFO, throttles the generator
// before the FIFO fills and keeps saturating accept/reject/overflow statistics.
module grng_sample_collector
    import grng_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int LOG2D     = 4,
    parameter int AF_MARGIN = 8,
    parameter int CNT_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    grng_sample_collector_if.slave  bus
);

    localparam logic [LOG2D:0] AF_THRESH = (LOG2D+1)'(DEPTH - AF_MARGIN - 1);

    sample_t          candidate, headSample;
    logic             pushReq, popReq, pushOk, rejectHit;
    logic [LOG2D:0]   count, countNext;
    logic [CNT_W-1:0] acceptCnt_q, acceptCnt_d;
    logic [CNT_W-1:0] rejectCnt_q, rejectCnt_d;
    logic             overflow_q, overflow_d;
    logic             genEnable_q, genEnable_d;

    // A reject wins over the tail flag: it never produces a sample.
    always_comb begin
        candidate.tail = bus.in_tail_case;
        candidate.data = bus.in_tail_case ? bus.in_tail_value : bus.in_normal_value;
        pushReq        = bus.in_valid && !bus.in_reject;
        rejectHit      = bus.in_valid && bus.in_reject;
        popReq         = (count != '0) && bus.out_ready;
    end

    grng_fwft_fifo #(
        .DEPTH (DEPTH),
        .LOG2D (LOG2D)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (pushReq),
        .pop_i       (popReq),
        .wdata_i     (candidate),
        .rdata_o     (headSample),
        .pushOk_o    (pushOk),
        .count_o     (count),
        .countNext_o (countNext)
    );

    always_comb begin
        acceptCnt_d = acceptCnt_q;
        rejectCnt_d = rejectCnt_q;
        overflow_d  = overflow_q;
        genEnable_d = (countNext <= AF_THRESH);
        if (bus.clear_stats) begin
            acceptCnt_d = '0;
            rejectCnt_d = '0;
            overflow_d  = 1'b0;
        end else begin
            if (pushOk && acceptCnt_q != '1) begin
                acceptCnt_d = acceptCnt_q + CNT_W'(1);
            end
            if (rejectHit && rejectCnt_q != '1) begin
                rejectCnt_d = rejectCnt_q + CNT_W'(1);
            end
            if (pushReq && !pushOk) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acceptCnt_q <= '0;
            rejectCnt_q <= '0;
            overflow_q  <= 1'b0;
            genEnable_q <= 1'b1;
        end else begin
            acceptCnt_q <= acceptCnt_d;
            rejectCnt_q <= rejectCnt_d;
            overflow_q  <= overflow_d;
            genEnable_q <= genEnable_d;
        end
    end

    assign bus.out_valid  = (count != '0);
    assign bus.out_data   = headSample.data;
    assign bus.out_tail   = headSample.tail;
    assign bus.gen_enable = genEnable_q;
    assign bus.accept_cnt = acceptCnt_q;
    assign bus.reject_cnt = rejectCnt_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: doc/grng_sample_collector.md
Name: grng_sample_collector

Overview:
- Downstream consumer of the Ziggurat final stage. Takes the per-cycle result flags (valid, tail_case, reject) and the two Q7.28 value buses.
- Selects the surviving sample, drops rejected iterations and buffers accepted samples in a FWFT FIFO for a valid/ready consumer.
- Asserts a generator-enable back-pressure signal so in-flight pipeline samples are never lost. Keeps accept/reject/overflow statistics for on-chip acceptance-rate checks.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 4.
- LOG2D, 4, log2(DEPTH).
- AF_MARGIN, 8, free entries reserved for samples still in the generator pipeline; must be < DEPTH.
- CNT_W, 32, width of statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  stage result valid this cycle.
- in_tail_case  in  1  result came from the tail path.
- in_reject  in  1  iteration rejected; no sample produced.
- in_normal_value  in  36  signed Q7.28 normal-path sample; zero when tail_case.
- in_tail_value  in  36  signed Q7.28 tail-path sample; zero when not tail_case.
- gen_enable  out  1  high = generator may issue new iterations.
- out_valid  out  1  sample available.
- out_ready  in  1  consumer accepts the sample this cycle.
- out_data  out  36  signed Q7.28 sample at FIFO head.
- out_tail  out  1  head sample came from the tail path.
- clear_stats  in  1  synchronous clear of counters and overflow flag.
- accept_cnt  out  CNT_W  samples written to the FIFO.
- reject_cnt  out  CNT_W  rejected iterations.
- overflow  out  1  sticky: a valid sample was dropped because the FIFO was full.

Behaviour:
- Reset (async, active-high): FIFO empty, rd/wr pointers = 0, count = 0, out_valid = 0, out_data = 0, out_tail = 0, gen_enable = 1, accept_cnt = 0, reject_cnt = 0, overflow = 0.
- Classification each cycle:
  - in_valid = 0: no action.
  - in_valid = 1 and in_reject = 1: reject_cnt += 1; nothing is written. in_reject takes precedence over in_tail_case.
  - in_valid = 1 and in_reject = 0: push candidate. Data is in_tail_value if in_tail_case, else in_normal_value; tail bit = in_tail_case.
- Push is accepted when count < DEPTH, or when count = DEPTH and a pop happens in the same cycle.
  - Accepted push: writes mem[wr_ptr]; wr_ptr increments modulo DEPTH; accept_cnt += 1.
  - Refused push: sample dropped; overflow is set and held until clear_stats or rst; accept_cnt is unchanged.
- Pop occurs when out_valid && out_ready; rd_ptr increments modulo DEPTH.
- Count update per cycle: +1 for push only, -1 for pop only, unchanged for both or neither.
- FWFT output:
  - out_valid = (count != 0).
  - out_data and out_tail are read combinationally from mem[rd_ptr]; both are 0 when empty.
  - Latency: in_valid at edge t gives out_valid high after edge t, so usable at edge t+1. No empty bypass.
- Empty with simultaneous push and out_ready: no pop, since out_valid = 0; count goes 0 -> 1.
- gen_enable is registered: the next value is (count_next <= DEPTH - AF_MARGIN - 1). Upstream must stop issuing iterations within AF_MARGIN-1 cycles of deassertion.
- Counters saturate at all-ones and do not wrap.
- clear_stats zeroes accept_cnt, reject_cnt and overflow on the next edge and has priority over any same-cycle increment. FIFO contents are unaffected.
- Reset mid-stream discards all buffered samples. Sign and fraction bits pass through unaltered; no rounding or conversion is applied.

Decomposition:
- Shared package grng_pkg: Q7.28 sample typedef (36-bit signed), FRAC_BITS = 28, and a sample_t struct {tail, data}.
- One natural sub-module, grng_fwft_fifo: parameterised sync FIFO with count, same-cycle push/pop, and pointer wrap.
- Classification, statistics and gen_enable logic stay in the top module.

Test Plan:
- Reset then idle -> out_valid = 0, gen_enable = 1, all counters 0, overflow = 0.
- Normal sample 0x0_1000_0000 (1.0), tail_case = 0, out_ready = 1 -> next cycle out_valid = 1, out_data = 0x010000000, out_tail = 0; popped; accept_cnt = 1.
- Alternating stream normal (-0.5 = 0xFF8000000), reject, tail (3.75 = 0x03C000000) -> FIFO holds exactly 2 entries in order {0xFF8000000, tail = 0} then {0x03C000000, tail = 1}; reject_cnt = 1.
- out_ready = 0, 20 consecutive accepted samples with DEPTH = 16, AF_MARGIN = 8:
  - gen_enable falls on the edge after the 8th push.
  - Pushes 17-20 are dropped; overflow = 1; accept_cnt = 16.
  - Then draining with out_ready = 1 returns 16 samples in order; gen_enable re-rises once count <= 7.
- FIFO full plus simultaneous push and pop -> push accepted, count stays 16, no overflow; wr/rd pointers wrap from 15 to 0 correctly.
- Two cases on clear_stats:
  - clear_stats asserted in the same cycle as a reject -> reject_cnt = 0.
  - rst asserted mid-drain -> out_valid drops immediately (async) and the FIFO is empty afterward.
